// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch/exec FSM with a small return-address stack.
// Optional interrupt entry is compiled in with `define SEQ_INTERRUPT_EN.
module pc_sequencer #(
  parameter int ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
  parameter int STACK_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] IRQ_VECTOR = ADDR_WIDTH'(12'h800)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  run,
  output logic                  fetch_req,
  output logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic                  fetch_ack,
  output logic                  instr_valid,
  input  logic                  exec_done,
  input  logic                  jump_en,
  input  logic                  call_en,
  input  logic                  ret_en,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
`ifdef SEQ_INTERRUPT_EN
  input  logic                  irq,
  output logic                  irq_ack,
`endif
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [1:0]            state,
  output logic                  stack_err
);

  localparam int IW = $clog2(STACK_DEPTH);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] FULL = CW'(STACK_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    EXEC  = 2'b10
  } state_t;

  state_t                st_q;
  logic                  req_q;
  logic                  iv_q;
  logic [ADDR_WIDTH-1:0] pc_q, pc_n;
  logic [CW-1:0]         cnt_q, cnt_n, cnt_m1;
  logic                  err_q, err_n;
  logic [ADDR_WIDTH-1:0] stk_q [STACK_DEPTH];
  logic [ADDR_WIDTH-1:0] stk_n [STACK_DEPTH];
  logic [ADDR_WIDTH-1:0] inc;
  logic                  done;

`ifdef SEQ_INTERRUPT_EN
  logic mask_q, mask_n;
  logic ack_q, ack_n;
  assign irq_ack = ack_q;
`endif

  assign fetch_req   = req_q;
  assign fetch_addr  = pc_q;
  assign pc          = pc_q;
  assign instr_valid = iv_q;
  assign state       = st_q;
  assign stack_err   = err_q;

  // The instr_valid cycle belongs to the decoder; completion is taken after it.
  assign done   = (st_q == EXEC) && !iv_q && exec_done;
  assign inc    = pc_q + ADDR_WIDTH'(1);
  assign cnt_m1 = cnt_q - CW'(1);

  always_comb begin
    stk_n = stk_q;
    cnt_n = cnt_q;
    pc_n  = pc_q;
    err_n = err_q;
`ifdef SEQ_INTERRUPT_EN
    mask_n = mask_q;
    ack_n  = 1'b0;
`endif
    if (done) begin
      if (ret_en) begin
`ifdef SEQ_INTERRUPT_EN
        mask_n = 1'b0;
`endif
        if (cnt_q != '0) begin
          pc_n  = stk_q[cnt_m1[IW-1:0]];
          cnt_n = cnt_m1;
        end else begin
          pc_n  = inc;
          err_n = 1'b1;
        end
      end else if (call_en) begin
        if (cnt_q != FULL) begin
          stk_n[cnt_q[IW-1:0]] = inc;
          cnt_n = cnt_q + CW'(1);
        end else begin
          err_n = 1'b1;
        end
        pc_n = jump_addr;
      end else if (jump_en) begin
        pc_n = jump_addr;
      end else begin
        pc_n = inc;
      end
`ifdef SEQ_INTERRUPT_EN
      // Interrupt saves the address the normal flow would have gone to.
      if (irq && !mask_q) begin
        if (cnt_n != FULL) begin
          stk_n[cnt_n[IW-1:0]] = pc_n;
          cnt_n = cnt_n + CW'(1);
        end else begin
          err_n = 1'b1;
        end
        pc_n   = IRQ_VECTOR;
        mask_n = 1'b1;
        ack_n  = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q  <= IDLE;
      req_q <= 1'b0;
      iv_q  <= 1'b0;
      pc_q  <= RESET_ADDR;
      cnt_q <= '0;
      err_q <= 1'b0;
      stk_q <= '{default: '0};
`ifdef SEQ_INTERRUPT_EN
      mask_q <= 1'b0;
      ack_q  <= 1'b0;
`endif
    end else begin
      iv_q  <= 1'b0;
      pc_q  <= pc_n;
      cnt_q <= cnt_n;
      err_q <= err_n;
      stk_q <= stk_n;
`ifdef SEQ_INTERRUPT_EN
      mask_q <= mask_n;
      ack_q  <= ack_n;
`endif
      unique case (st_q)
        IDLE: begin
          if (run) begin
            st_q  <= FETCH;
            req_q <= 1'b1;
          end
        end
        FETCH: begin
          if (fetch_ack) begin
            st_q  <= EXEC;
            req_q <= 1'b0;
            iv_q  <= 1'b1;
          end
        end
        EXEC: begin
          if (done) begin
            st_q  <= run ? FETCH : IDLE;
            req_q <= run;
          end
        end
        default: begin
          st_q  <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized scoreboard bench for pc_sequencer (default build).
// Expected fetch addresses come from a queue-based stack model.
module tb_pc_sequencer;

  typedef struct packed {
    logic [11:0] addr;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic        fetch_req;
  logic [11:0] fetch_addr;
  logic        fetch_ack = 1'b0;
  logic        instr_valid;
  logic        exec_done = 1'b0;
  logic        jump_en = 1'b0;
  logic        call_en = 1'b0;
  logic        ret_en = 1'b0;
  logic [11:0] jump_addr = '0;
  logic [11:0] pc;
  logic [1:0]  state;
  logic        stack_err;

  int checks = 0;
  int fails = 0;
  bit dead = 0;
  int force_d = -1;
  int emax = 3;

  exp_t        sb [$];
  logic [11:0] m_pc;
  logic        m_err;
  logic [11:0] m_stk [$];
  bit          prev_fa = 0;

  pc_sequencer dut (
    .clk(clk), .reset_n(reset_n), .run(run),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .instr_valid(instr_valid),
    .exec_done(exec_done), .jump_en(jump_en),
    .call_en(call_en), .ret_en(ret_en),
    .jump_addr(jump_addr), .pc(pc), .state(state),
    .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  // Monitor: fetch handshakes against the scoreboard, instr_valid timing.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      prev_fa = 0;
    end else begin
      if (prev_fa || instr_valid) begin
        checks++;
        if (instr_valid !== prev_fa) begin
          fails++;
          $display("FAIL instr_valid got=%0b exp=%0b t=%0t",
                   instr_valid, prev_fa, $time);
        end
      end
      if (fetch_req && fetch_ack) begin
        checks++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL fetch_unexpected addr=%h", fetch_addr);
        end else begin
          e = sb.pop_front();
          if (fetch_addr !== e.addr || stack_err !== e.err) begin
            fails++;
            $display("FAIL fetch addr=%h err=%0b exp addr=%h err=%0b",
                     fetch_addr, stack_err, e.addr, e.err);
          end
        end
      end
      prev_fa = fetch_req && fetch_ack;
    end
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic model(input logic rr, input logic cc, input logic jj,
                       input logic [11:0] ja);
    if (rr) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else begin
        m_pc  = m_pc + 12'd1;
        m_err = 1'b1;
      end
    end else if (cc) begin
      if (m_stk.size() < 4) m_stk.push_back(m_pc + 12'd1);
      else m_err = 1'b1;
      m_pc = ja;
    end else if (jj) begin
      m_pc = ja;
    end else begin
      m_pc = m_pc + 12'd1;
    end
  endtask

  task automatic model_reset();
    m_pc  = 12'h000;
    m_err = 1'b0;
    m_stk.delete();
    sb.delete();
    sb.push_back('{addr: 12'h000, err: 1'b0});
  endtask

  task automatic do_instr(input logic rr, input logic cc, input logic jj,
                          input logic [11:0] ja, input logic ra);
    int n;
    int d;
    int e;
    if (dead) return;
    n = 0;
    while (!fetch_req && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!fetch_req) begin
      checks++;
      fails++;
      $display("FAIL fetch_timeout fetch_req=%0b exp=1", fetch_req);
      dead = 1;
      return;
    end
    d = (force_d >= 0) ? force_d : $urandom_range(0, 3);
    repeat (d) begin
      chk("fetch_req_stable", 32'(fetch_req), 32'd1);
      chk("fetch_addr_stable", 32'(fetch_addr), 32'(m_pc));
      exec_done = ($urandom_range(0, 2) == 0);
      ret_en    = 1'($urandom_range(0, 1));
      call_en   = 1'($urandom_range(0, 1));
      jump_en   = 1'($urandom_range(0, 1));
      jump_addr = 12'($urandom);
      if ($urandom_range(0, 3) == 0) run = 1'b0;
      @(posedge clk); #1;
    end
    chk("fetch_addr_at_ack", 32'(fetch_addr), 32'(m_pc));
    exec_done = 1'b0;
    ret_en    = 1'b0;
    call_en   = 1'b0;
    jump_en   = 1'b0;
    fetch_ack = 1'b1;
    @(posedge clk); #1;
    fetch_ack = 1'b0;
    e = $urandom_range(1, emax);
    repeat (e) begin
      fetch_ack = 1'($urandom_range(0, 1));
      ret_en    = 1'($urandom_range(0, 1));
      call_en   = 1'($urandom_range(0, 1));
      jump_en   = 1'($urandom_range(0, 1));
      jump_addr = 12'($urandom);
      @(posedge clk); #1;
      chk("pc_hold", 32'(pc), 32'(m_pc));
    end
    fetch_ack = 1'b0;
    exec_done = 1'b1;
    ret_en    = rr;
    call_en   = cc;
    jump_en   = jj;
    jump_addr = ja;
    run       = ra;
    model(rr, cc, jj, ja);
    sb.push_back('{addr: m_pc, err: m_err});
    @(posedge clk); #1;
    exec_done = 1'b0;
    ret_en    = 1'b0;
    call_en   = 1'b0;
    jump_en   = 1'b0;
    chk("pc_after_exec", 32'(pc), 32'(m_pc));
    if (!ra) begin
      repeat (2) begin
        @(posedge clk); #1;
      end
      chk("idle_state", 32'(state), 32'd0);
      chk("idle_req", 32'(fetch_req), 32'd0);
      run = 1'b1;
    end
  endtask

  initial begin
    time t0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_req", 32'(fetch_req), 32'd0);
    chk("rst_pc", 32'(pc), 32'h000);
    chk("rst_err", 32'(stack_err), 32'd0);
    chk("rst_iv", 32'(instr_valid), 32'd0);
    reset_n = 1'b1;
    run = 1'b1;
    @(posedge clk); #1;
    t0 = $time;

    // back-to-back minimum-latency instructions
    force_d = 0;
    emax = 1;
    repeat (3) do_instr(0, 0, 0, 12'h0, 1);
    chk("three_instr_cycles", 32'($time - t0), 32'd90);
    emax = 3;
    force_d = 4;
    do_instr(0, 0, 0, 12'h0, 1);
    force_d = -1;

    // call / return / call-beats-jump
    do_instr(0, 0, 1, 12'h010, 1);
    do_instr(0, 1, 0, 12'h200, 1);
    chk("call_pc", 32'(pc), 32'h200);
    do_instr(1, 0, 0, 12'h0, 1);
    chk("ret_pc", 32'(pc), 32'h011);
    do_instr(0, 1, 1, 12'h300, 0);
    chk("call_wins", 32'(pc), 32'h300);
    do_instr(1, 0, 0, 12'h0, 1);

    // wrap
    do_instr(0, 0, 1, 12'hFFF, 1);
    do_instr(0, 0, 0, 12'h0, 1);
    chk("wrap_pc", 32'(pc), 32'h000);

    // overflow, LIFO unwind, underflow
    for (int i = 0; i < 5; i++) do_instr(0, 1, 0, 12'(12'h100 + i * 16), 1);
    chk("overflow_err", 32'(stack_err), 32'd1);
    for (int i = 0; i < 5; i++) do_instr(1, 0, 0, 12'h0, 1);
    chk("underflow_err", 32'(stack_err), 32'd1);

    // reset during FETCH
    while (!fetch_req) begin
      @(posedge clk); #1;
    end
    #2 reset_n = 1'b0;
    #1;
    chk("async_req", 32'(fetch_req), 32'd0);
    chk("async_pc", 32'(pc), 32'h000);
    chk("async_state", 32'(state), 32'd0);
    chk("async_err", 32'(stack_err), 32'd0);
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      do_instr(1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 2) == 0),
               1'($urandom_range(0, 1)),
               12'($urandom),
               1'($urandom_range(0, 6) != 0));
    end
    run = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Instruction-sequencing controller that owns the 12-bit program counter and steps it through fetch/execute.
- Drives fetch requests to instruction memory and hands the fetched instruction to the decoder.
- Waits for the datapath to finish, then picks the next PC: increment, jump, call or return.
- Includes a small return-address stack. Sits between instruction memory, decoder and execute datapath.

Parameters:
ADDR_WIDTH, 12, PC / address width
RESET_ADDR, 12'h000, PC value after reset
STACK_DEPTH, 4, return-address stack entries (power of 2, >=2)
IRQ_VECTOR, 12'h800, interrupt target address (used only with SEQ_INTERRUPT_EN)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
run  in  1  level; sequencer fetches while high
fetch_req  out  1  instruction memory request
fetch_addr  out  ADDR_WIDTH  fetch address, always equals pc
fetch_ack  in  1  memory has returned the instruction this cycle
instr_valid  out  1  one-cycle pulse: instruction is ready for the decoder
exec_done  in  1  datapath has finished the current instruction
jump_en  in  1  take jump_addr (sampled with exec_done)
call_en  in  1  push return address, take jump_addr (sampled with exec_done)
ret_en  in  1  pop stack into pc (sampled with exec_done)
jump_addr  in  ADDR_WIDTH  branch/call target
pc  out  ADDR_WIDTH  current program counter
state  out  2  FSM state: IDLE=00, FETCH=01, EXEC=10
stack_err  out  1  sticky overflow/underflow flag

Behaviour:
- Reset (async, reset_n low): takes effect immediately, mid-fetch included; no wait for fetch_ack.
  - pc=RESET_ADDR, state=IDLE, fetch_req=0, instr_valid=0, stack empty, stack_err=0.
- IDLE: fetch_req=0. When run=1 at a clock edge, go to FETCH; fetch_req is 1 in the following cycle.
- FETCH:
  - fetch_req=1, fetch_addr=pc, both held stable until fetch_ack.
  - On fetch_ack: next cycle state=EXEC, fetch_req=0, instr_valid=1 for exactly one cycle.
  - fetch_ack outside FETCH is ignored.
  - run dropping during FETCH does not abort the fetch.
- EXEC: pc holds. On exec_done, pc updates at that edge. Priority is ret_en > call_en > jump_en > increment:
  - ret_en, stack non-empty: pc=top entry, pop.
  - ret_en, stack empty: pc=pc+1, stack_err=1.
  - call_en, stack not full: push pc+1, pc=jump_addr.
  - call_en, stack full: push dropped (contents unchanged), pc=jump_addr, stack_err=1.
  - jump_en: pc=jump_addr.
  - none asserted: pc=pc+1.
  - Next state: FETCH if run=1, else IDLE.
- exec_done outside EXEC is ignored; jump_en/call_en/ret_en without exec_done are ignored.
- Arithmetic: pc+1 wraps modulo 2^ADDR_WIDTH (12'hFFF -> 12'h000); a pushed return address wraps the same way.
- Minimum instruction time is 3 cycles: request cycle, instr_valid cycle, exec_done cycle (fetch_ack and exec_done both asserted in their first eligible cycle).
- stack_err clears only on reset.

Optional Feature:
SEQ_INTERRUPT_EN
- Defined:
  - Adds input irq (level) and output irq_ack.
  - At exec_done with irq=1, the interrupt outranks ret/call/jump: push the would-be next pc (normal priority result), pc=IRQ_VECTOR, irq_ack=1 for one cycle after that edge.
  - Stack full: push dropped, stack_err=1, vector still taken.
  - Further interrupts are masked until the next ret_en executes.
- Undefined: no irq/irq_ack ports, no interrupt logic.

Test Plan:
- Reset release, run=1, fetch_ack and exec_done asserted in their first eligible cycle, no branches -> fetch_addr 000,001,002 on successive instructions; instr_valid once per 3 cycles.
- fetch_ack delayed 4 cycles -> fetch_req and fetch_addr stable throughout, instr_valid exactly one cycle after the ack.
- pc=0x010, call_en, jump_addr=0x200 -> pc=0x200. Later ret_en -> pc=0x011. jump_en and call_en together -> call wins.
- 5 nested calls with STACK_DEPTH=4 -> stack_err=1, fifth return address lost. 4 returns -> correct LIFO order; a 5th ret_en -> pc+1, stack_err still 1.
- pc=0xFFF with increment -> pc=0x000. reset_n low during FETCH -> fetch_req=0 and pc=RESET_ADDR without a clock edge.
- SEQ_INTERRUPT_EN: irq=1 at exec_done with pc=0x020 -> pc=0x800, irq_ack pulse. ret_en -> pc=0x021.
